// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and instruction fetch sequencer with branch/jump/halt/exception redirect
// Optional feature macro: PC_FETCH_EXC_VECTOR_EN (exception vectors to EXC_VECTOR instead of halting)
module pc_fetch #(
    parameter int              BITS       = 32,
    parameter logic [BITS-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [BITS-1:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic            clk,
    input  logic            rst_,
    output logic [BITS-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    output logic            load_instr,
    output logic            flush,
    input  logic            jmp,
    input  logic            jal,
    input  logic            jreg,
    input  logic            breq,
    input  logic            brne,
    input  logic            halt,
    input  logic            exception,
    input  logic            equal,
    input  logic            not_equal,
    input  logic [25:0]     addr,
    input  logic [15:0]     imm,
    input  logic [BITS-1:0] jreg_data,
    output logic [BITS-1:0] ret_addr,
    output logic [BITS-1:0] epc,
    output logic            halted
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALTED} state_t;

    state_t          state, state_n;
    logic [BITS-1:0] pc, pc_n;
    logic [BITS-1:0] decode_pc, decode_pc_n;
    logic            decode_valid, decode_valid_n;
    logic [BITS-1:0] epc_n;
    logic            load_c, flush_c;
    logic            taken;
    logic [BITS-1:0] target;

    assign ret_addr  = decode_pc + BITS'(4);
    assign imem_addr = pc;
    assign halted    = (state == S_HALTED);

    // Outputs are forced quiet while reset is held, even if an ack arrives.
    assign imem_req   = rst_ && (state != S_HALTED);
    assign load_instr = rst_ && load_c;
    assign flush      = rst_ && flush_c;

    // Redirect decision and target select for the instruction in decode.
    always_comb begin
        taken = decode_valid & (jmp | jal | jreg | (breq & equal) | (brne & not_equal));
        if (jmp || jal)
            target = {ret_addr[BITS-1:28], addr, 2'b00};
        else if (jreg)
            target = jreg_data;
        else
            target = ret_addr + {{(BITS-18){imm[15]}}, imm, 2'b00};
    end

    // Next-state and strobe logic: exception > halt > redirect > sequential fetch.
    always_comb begin
        state_n        = state;
        pc_n           = pc;
        decode_pc_n    = decode_pc;
        decode_valid_n = 1'b0;
        epc_n          = epc;
        load_c         = 1'b0;
        flush_c        = 1'b0;
        if (state != S_HALTED) begin
            if (decode_valid && exception) begin
                flush_c = 1'b1;
                epc_n   = decode_pc;
`ifdef PC_FETCH_EXC_VECTOR_EN
                pc_n    = EXC_VECTOR;
                state_n = S_FETCH;
`else
                state_n = S_HALTED;
`endif
            end else if (decode_valid && halt) begin
                flush_c = 1'b1;
                state_n = S_HALTED;
            end else if (taken) begin
                // Any ack this cycle belongs to the wrong path and is dropped.
                flush_c = 1'b1;
                pc_n    = target;
                state_n = S_FETCH;
            end else if (imem_ack) begin
                load_c         = 1'b1;
                decode_pc_n    = pc;
                pc_n           = pc + BITS'(4);
                decode_valid_n = 1'b1;
                state_n        = S_FETCH;
            end else begin
                state_n = S_WAIT;
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            decode_pc    <= RESET_PC;
            decode_valid <= 1'b0;
            epc          <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            decode_pc    <= decode_pc_n;
            decode_valid <= decode_valid_n;
            epc          <= epc_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - scoreboard testbench for pc_fetch with directed and random stimulus
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_PC = 32'h0000_0080;

    logic        clk, rst_;
    logic [31:0] imem_addr, ret_addr, epc, jreg_data;
    logic        imem_req, imem_ack, load_instr, flush, halted;
    logic        jmp, jal, jreg, breq, brne, halt, exception, equal, not_equal;
    logic [25:0] addr;
    logic [15:0] imm;

    pc_fetch dut (
        .clk(clk), .rst_(rst_), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ack(imem_ack), .load_instr(load_instr), .flush(flush),
        .jmp(jmp), .jal(jal), .jreg(jreg), .breq(breq), .brne(brne),
        .halt(halt), .exception(exception), .equal(equal), .not_equal(not_equal),
        .addr(addr), .imm(imm), .jreg_data(jreg_data), .ret_addr(ret_addr),
        .epc(epc), .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        load;
        logic        flush;
        logic [31:0] ret;
        logic [31:0] epc;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Reference model: program-level view of where fetch goes next.
    logic [31:0] m_pc, m_dpc, m_epc;
    logic        m_dv, m_halted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_dpc = RST_PC; m_epc = 32'd0; m_dv = 1'b0; m_halted = 1'b0;
    endtask

    // Opcodes: 0 none, 1 jmp, 2 jal, 3 jreg, 4 breq, 5 brne, 6 halt, 7 exception
    task automatic drive(input logic ack, input int op, input logic eq, input logic ne,
                         input logic [25:0] a, input logic [15:0] im, input logic [31:0] jd);
        exp_t        e;
        logic [31:0] ra;
        logic        is_redirect;
        @(negedge clk);
        rst_ = 1'b1;
        imem_ack = ack; equal = eq; not_equal = ne; addr = a; imm = im; jreg_data = jd;
        jmp = (op == 1); jal = (op == 2); jreg = (op == 3); breq = (op == 4);
        brne = (op == 5); halt = (op == 6); exception = (op == 7);
        ra = m_dpc + 32'd4;
        e.req = !m_halted; e.addr = m_pc; e.ret = ra; e.epc = m_epc; e.halted = m_halted;
        e.load = 1'b0; e.flush = 1'b0;
        is_redirect = m_dv && (op == 1 || op == 2 || op == 3 || (op == 4 && eq) || (op == 5 && ne));
        if (!m_halted) begin
            if (m_dv && op == 7) begin
                e.flush = 1'b1; m_epc = m_dpc;
`ifdef PC_FETCH_EXC_VECTOR_EN
                m_pc = EXC_PC;
`else
                m_halted = 1'b1;
`endif
                m_dv = 1'b0;
            end else if (m_dv && op == 6) begin
                e.flush = 1'b1; m_halted = 1'b1; m_dv = 1'b0;
            end else if (is_redirect) begin
                e.flush = 1'b1;
                if (op == 1 || op == 2)
                    m_pc = (ra & 32'hF000_0000) | ({6'b0, a} << 2);
                else if (op == 3)
                    m_pc = jd;
                else
                    m_pc = ra + 32'(int'($signed(im)) * 4);
                m_dv = 1'b0;
            end else if (ack) begin
                e.load = 1'b1; m_dpc = m_pc; m_pc = m_pc + 32'd4; m_dv = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
        end
        exp_q.push_back(e);
    endtask

    // Reset asserted for one cycle with a live ack to prove outputs stay quiet.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst_ = 1'b0; imem_ack = 1'b1;
        model_reset();
        e.req = 1'b0; e.addr = RST_PC; e.load = 1'b0; e.flush = 1'b0;
        e.ret = RST_PC + 32'd4; e.epc = 32'd0; e.halted = 1'b0;
        exp_q.push_back(e);
    endtask

    // Monitor: sample mid-cycle and compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_req",   {31'd0, imem_req},   {31'd0, e.req});
                chk("imem_addr",  imem_addr,           e.addr);
                chk("load_instr", {31'd0, load_instr}, {31'd0, e.load});
                chk("flush",      {31'd0, flush},      {31'd0, e.flush});
                chk("ret_addr",   ret_addr,            e.ret);
                chk("epc",        epc,                 e.epc);
                chk("halted",     {31'd0, halted},     {31'd0, e.halted});
            end
        end
    end

    initial begin
        int op, r, hcnt;
        rst_ = 1'b0; imem_ack = 1'b0; equal = 1'b0; not_equal = 1'b0;
        addr = '0; imm = '0; jreg_data = '0;
        jmp = 0; jal = 0; jreg = 0; breq = 0; brne = 0; halt = 0; exception = 0;
        model_reset();

        // Sequential fetch, then a three-cycle stall at address 8.
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        // Jump-register to 0x40 with a discarded ack, then JAL 0x100 from 0x40.
        drive(1, 3, 0, 0, 0, 0, 32'h40);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 2, 0, 0, 26'h100, 0, 0);
        // Halt with a simultaneous ack, sit halted, then reset.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 6, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        // Walk to decode_pc=0x10: BEQ back to 0x0C taken, then untaken.
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 4, 1, 0, 0, 16'hFFFE, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 4, 0, 1, 0, 16'hFFFE, 0);
        // Exception from decode_pc=0x24.
        drive(1, 3, 0, 0, 0, 0, 32'h24);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 7, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Randomized phase; leave HALTED via reset after a few cycles.
        hcnt = 0;
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 31);
            op = (r <= 2) ? r + 1 : (r <= 4) ? 4 : (r <= 6) ? 5 : (r == 7) ? 6 : (r == 8) ? 7 : 0;
            hcnt = m_halted ? hcnt + 1 : 0;
            if (hcnt > 2) begin
                do_reset();
                hcnt = 0;
            end else begin
                drive(($urandom_range(0, 3) != 0), op, 1'($urandom), 1'($urandom),
                      26'($urandom), 16'($urandom), $urandom & 32'hFFFF_FFFC);
            end
        end

        @(negedge clk);
        #5;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameters: BITS, 32, datapath width; RESET_PC, 32'h0000_0000, first fetch address; EXC_VECTOR, 32'h0000_0080, exception handler address.
REQ-002 clk  input  1  system clock; reset rst_, asynchronous, active-low; clock clk.
REQ-003 rst_  input  1  asynchronous active-low reset.
REQ-004 imem_addr  output  BITS  instruction memory byte address (equals pc).
REQ-005 imem_req  output  1  fetch request.
REQ-006 imem_ack  input  1  instruction word valid this cycle.
REQ-007 load_instr  output  1  instruction register capture strobe.
REQ-008 flush  output  1  instruction register must load NOP next edge.
REQ-009 jmp, jal, jreg, breq, brne, halt, exception  input  1 each  decode flags of the instruction currently held.
REQ-010 equal, not_equal  input  1 each  branch compare results.
REQ-011 addr  input  26  jump target field; imm  input  16  branch offset field.
REQ-012 jreg_data  input  BITS  register value for jump-register.
REQ-013 ret_addr  output  BITS  link value, decode_pc+4.
REQ-014 epc  output  BITS  PC of the faulting instruction.
REQ-015 halted  output  1  fetch stopped.

Function
REQ-016 Internal registers: pc, decode_pc (address of the held instruction), decode_valid, state ∈ {FETCH, WAIT, HALTED}.
REQ-017 FETCH/WAIT: imem_req=1; imem_addr=pc. On imem_ack without redirect: load_instr=1 (combinational), decode_pc<=pc, pc<=pc+4 (mod 2^BITS), decode_valid<=1, state<=FETCH.
REQ-018 FETCH with no imem_ack: state<=WAIT, pc held, decode_valid<=0; WAIT holds until imem_ack.
REQ-019 Decode flags are acted on only when decode_valid=1; decode_valid is 1 for exactly one cycle per captured instruction.
REQ-020 Taken redirect = decode_valid & (jmp | jal | jreg | (breq & equal) | (brne & not_equal)).
REQ-021 Targets: jmp/jal -> {ret_addr[31:28], addr, 2'b00}; jreg -> jreg_data; breq/brne -> ret_addr + (sign-extended imm << 2).
REQ-022 On a taken redirect: pc<=target, flush=1, load_instr=0, decode_valid<=0, state<=FETCH; an imem_ack in the same cycle is discarded.
REQ-023 Untaken branch (decode_valid & breq & !equal, or brne & !not_equal) causes no redirect; sequential fetch continues.
REQ-024 Priority when decode_valid: exception > halt > redirect > sequential fetch.
REQ-025 halt: state<=HALTED, load_instr=0, flush=1; in HALTED imem_req=0, load_instr=0, pc frozen, halted=1, and the only exit is reset.
REQ-026 exception: epc<=decode_pc, flush=1, load_instr=0; further behaviour per REQ-030/031.
REQ-027 imem_addr changes while imem_req=1 only on redirect; otherwise it stays stable until imem_ack.

Reset
REQ-028 On rst_ low, regardless of state or outstanding request: pc=RESET_PC, decode_pc=RESET_PC, epc=0, decode_valid=0, state=FETCH; load_instr=0, flush=0, halted=0; imem_req=1 from the first cycle after release.

Configuration
REQ-029 Macro PC_FETCH_EXC_VECTOR_EN selects exception handling.
REQ-030 Defined: exception sets pc<=EXC_VECTOR and state<=FETCH; fetching continues.
REQ-031 Undefined: exception behaves as halt (state<=HALTED); epc is still captured.

Verification
REQ-032 Reset release, imem_ack always 1 -> imem_addr 0,4,8,C on successive cycles; load_instr high each cycle.
REQ-033 imem_ack low for 3 cycles at address 8 -> imem_addr holds 8, load_instr=0, then pc=C after ack.
REQ-034 BEQ at decode_pc=0x10, imm=16'hFFFE, equal=1 -> flush=1, next imem_addr=0x0C; with equal=0 -> next address sequential.
REQ-035 JAL at decode_pc=0x40, addr=26'h100 -> ret_addr=0x44, next imem_addr=0x400; JR with jreg_data=0x200 -> next imem_addr=0x200.
REQ-036 exception at decode_pc=0x24 -> epc=0x24; with macro defined next imem_addr=0x80, without it halted=1 and imem_req=0.
REQ-037 halt together with imem_ack, then rst_ pulse in HALTED -> fetched word dropped, halted=1; after reset imem_addr=0, halted=0.
